// File: rtl/uart_tx_framer.sv
// UART transmitter with an internal synchronous FIFO: configurable data bits, parity and stop bits,
// break generation, and a clocks-per-bit divisor so it runs directly from the system clock.
module uart_tx_framer #(
   parameter int parm_CLKS_PER_BIT = 347,
   parameter int parm_DATA_BITS    = 8,
   parameter int parm_PARITY       = 0,
   parameter int parm_STOP_BITS    = 1,
   parameter int parm_FIFO_DEPTH   = 2048,
   parameter int parm_READY_SPACE  = 36
) (
   input  logic                               i_clk_40mhz,
   input  logic                               i_rst_40mhz,
   input  logic [parm_DATA_BITS-1:0]          i_tx_data,
   input  logic                               i_tx_valid,
   output logic                               o_tx_ready,
   output logic                               o_tx_overflow,
   output logic [$clog2(parm_FIFO_DEPTH):0]   o_fifo_count,
   input  logic                               i_break,
   output logic                               o_busy,
   output logic                               eo_uart_tx,
   output logic [2:0]                         o_dbg_state
);

   localparam int AW = $clog2(parm_FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int BW = 16;
   localparam bit ODD_PAR = (parm_PARITY == 2);

   // Handshake: i_tx_valid is a write strobe; each high cycle enqueues one entry unless the FIFO
   // is full. o_tx_ready is advisory and lags the FIFO by a cycle.
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4,
      ST_BREAK  = 3'd5
   } state_t;

   state_t                    state_q, state_d;
   logic [BW-1:0]             baud_q;
   logic [3:0]                bit_q, bit_d;
   logic [parm_DATA_BITS-1:0] shift_q, shift_d;
   logic                      par_q, par_d;
   logic                      tx_d;
   logic                      pop;
   logic                      bit_end;

   logic [parm_DATA_BITS-1:0] mem [parm_FIFO_DEPTH];
   logic [AW-1:0]             wr_ptr, rd_ptr;
   logic [CW-1:0]             cnt_q;
   logic                      full, empty, wr_en;

   assign full        = (cnt_q == CW'(parm_FIFO_DEPTH));
   assign empty       = (cnt_q == '0);
   assign wr_en       = i_tx_valid && !full;
   assign bit_end     = (state_q != ST_IDLE) && (baud_q == BW'(parm_CLKS_PER_BIT - 1));
   assign o_dbg_state = state_q;

   always_ff @(posedge i_clk_40mhz) begin
      if (wr_en) mem[wr_ptr] <= i_tx_data;
   end

   always_ff @(posedge i_clk_40mhz or negedge i_rst_40mhz) begin
      if (!i_rst_40mhz) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt_q  <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + AW'(1);
         if (pop)   rd_ptr <= rd_ptr + AW'(1);
         case ({wr_en, pop})
            2'b10:   cnt_q <= cnt_q + CW'(1);
            2'b01:   cnt_q <= cnt_q - CW'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   always_ff @(posedge i_clk_40mhz or negedge i_rst_40mhz) begin
      if (!i_rst_40mhz) begin
         state_q       <= ST_IDLE;
         baud_q        <= '0;
         bit_q         <= '0;
         shift_q       <= '0;
         par_q         <= 1'b0;
         eo_uart_tx    <= 1'b1;
         o_fifo_count  <= '0;
         o_tx_ready    <= 1'b1;
         o_busy        <= 1'b0;
         o_tx_overflow <= 1'b0;
      end else begin
         state_q       <= state_d;
         bit_q         <= bit_d;
         shift_q       <= shift_d;
         par_q         <= par_d;
         eo_uart_tx    <= tx_d;
         if (state_q == ST_IDLE || bit_end) baud_q <= '0;
         else                               baud_q <= baud_q + BW'(1);
         o_fifo_count  <= cnt_q;
         o_tx_ready    <= (CW'(parm_FIFO_DEPTH) - cnt_q) >= CW'(parm_READY_SPACE);
         o_busy        <= (state_q != ST_IDLE);
         o_tx_overflow <= i_tx_valid && full;
      end
   end

   always_comb begin
      state_d = state_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      par_d   = par_q;
      pop     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (i_break) state_d = ST_BREAK;
            else if (!empty) begin
               pop     = 1'b1;
               state_d = ST_START;
            end
         end
         ST_START: begin
            if (bit_end) begin
               state_d = ST_DATA;
               bit_d   = '0;
            end
         end
         ST_DATA: begin
            if (bit_end) begin
               shift_d = shift_q >> 1;
               if (bit_q == 4'(parm_DATA_BITS - 1)) begin
                  bit_d   = '0;
                  state_d = (parm_PARITY != 0) ? ST_PARITY : ST_STOP;
               end else begin
                  bit_d = bit_q + 4'd1;
               end
            end
         end
         ST_PARITY: begin
            if (bit_end) begin
               state_d = ST_STOP;
               bit_d   = '0;
            end
         end
         ST_STOP: begin
            if (bit_end) begin
               if (bit_q == 4'(parm_STOP_BITS - 1)) begin
                  bit_d = '0;
                  // Break wins over queued data; a new frame follows the stop bits with no idle gap.
                  if (i_break) state_d = ST_BREAK;
                  else if (!empty) begin
                     pop     = 1'b1;
                     state_d = ST_START;
                  end else begin
                     state_d = ST_IDLE;
                  end
               end else begin
                  bit_d = bit_q + 4'd1;
               end
            end
         end
         ST_BREAK: begin
            if (bit_end && !i_break) begin
               state_d = ST_STOP;
               bit_d   = '0;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (pop) begin
         shift_d = mem[rd_ptr];
         par_d   = (^mem[rd_ptr]) ^ ODD_PAR;
      end
   end

   // Line level follows the next state so it changes on the same edge as the FSM.
   always_comb begin
      tx_d = 1'b1;
      case (state_d)
         ST_IDLE:   tx_d = 1'b1;
         ST_START:  tx_d = 1'b0;
         ST_DATA:   tx_d = shift_d[0];
         ST_PARITY: tx_d = par_d;
         ST_STOP:   tx_d = 1'b1;
         ST_BREAK:  tx_d = 1'b0;
         default:   tx_d = 1'b1;
      endcase
   end

endmodule
